// File: rtl/dvsd_8216acc_if.sv
// Product-in / frame-total-out handshake bundle for the dvsd_8216acc frame accumulator.
// The master drives products and takes totals; the slave is the accumulator.
interface dvsd_8216acc_if #(
  parameter int unsigned ACC_W = 24
) ();
  logic [15:0]      m;
  logic             m_valid;
  logic             m_ready;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             acc_ovf;

  modport master (
    output m, m_valid, clear, acc_ready,
    input  m_ready, acc_out, acc_valid, acc_ovf
  );

  modport slave (
    input  m, m_valid, clear, acc_ready,
    output m_ready, acc_out, acc_valid, acc_ovf
  );
endinterface

// File: rtl/dvsd_8216acc.sv
// Frame accumulator: sums COUNT unsigned 16-bit products, then holds the total on a valid/ready
// output. Define DVSD_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module dvsd_8216acc #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned COUNT = 4
) (
  input logic              clock,
  input logic              reset_n,
  dvsd_8216acc_if.slave    acc_if_io
);

  localparam int unsigned   CntW    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(COUNT - 1);

  typedef enum logic {StAccum, StHold} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             accept;

  assign accept = acc_if_io.m_valid & (state_q == StAccum);
  // One extra bit captures the carry out of the accumulator.
  assign sum    = {1'b0, acc_q} + (ACC_W + 1)'(acc_if_io.m);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (acc_if_io.clear) begin
      state_d = StAccum;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (accept) begin
`ifdef DVSD_ACC_SATURATE_EN
            acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            ovf_d = ovf_q | sum[ACC_W];
            if (cnt_q == CntLast) begin
              cnt_d   = '0;
              state_d = StHold;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StHold: begin
          if (acc_if_io.acc_ready) begin
            state_d = StAccum;
            acc_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode the state register only; no path from m or acc_ready.
  assign acc_if_io.m_ready   = (state_q == StAccum);
  assign acc_if_io.acc_valid = (state_q == StHold);
  assign acc_if_io.acc_out   = acc_q;
  assign acc_if_io.acc_ovf   = ovf_q;

endmodule

// File: tb/tb_dvsd_8216acc.sv
// Scoreboard bench for dvsd_8216acc: a 24-bit and a 16-bit instance, directed frames, monitors
// compare every transferred total against hand-computed expectations.
module tb_dvsd_8216acc;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  dvsd_8216acc_if #(.ACC_W(24)) ifa ();
  dvsd_8216acc_if #(.ACC_W(16)) ifb ();

  dvsd_8216acc #(.ACC_W(24), .COUNT(4)) u_dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .acc_if_io (ifa.slave)
  );

  dvsd_8216acc #(.ACC_W(16), .COUNT(4)) u_dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .acc_if_io (ifb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected totals: {ovf, acc}
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && ifa.acc_valid && ifa.acc_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_total", {ifa.acc_ovf, 8'd0, ifa.acc_out}, 33'h1ffffffff);
      else chk("a_total", {ifa.acc_ovf, 8'd0, ifa.acc_out}, q_a.pop_front());
    end
  end

  always @(negedge clock) begin
    if (reset_n && ifb.acc_valid && ifb.acc_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_total", {ifb.acc_ovf, 16'd0, ifb.acc_out}, 33'h1ffffffff);
      else chk("b_total", {ifb.acc_ovf, 16'd0, ifb.acc_out}, q_b.pop_front());
    end
  end

  function automatic logic [32:0] ex(input logic ovf, input logic [31:0] v);
    return {ovf, v};
  endfunction

  // Entered and left at posedge+1; waits (bounded) for m_ready, holds m_valid for the accept edge.
  task automatic send_a(input logic [15:0] v, input int gap);
    int n;
    n = 0;
    ifa.m = v;
    ifa.m_valid = 1'b1;
    while (!ifa.m_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) chk("a_m_ready_timeout", 33'd0, 33'd1);
    @(posedge clock); #1;
    ifa.m_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_b(input logic [15:0] v);
    int n;
    n = 0;
    ifb.m = v;
    ifb.m_valid = 1'b1;
    while (!ifb.m_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) chk("b_m_ready_timeout", 33'd0, 33'd1);
    @(posedge clock); #1;
    ifb.m_valid = 1'b0;
  endtask

  initial begin
    logic [32:0] ovf_exp;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    ifa.m = '0; ifa.m_valid = 1'b0; ifa.clear = 1'b0; ifa.acc_ready = 1'b1;
    ifb.m = '0; ifb.m_valid = 1'b0; ifb.clear = 1'b0; ifb.acc_ready = 1'b1;
    #3;
    chk("rst_acc_out", {9'd0, ifa.acc_out}, 33'd0);
    chk("rst_acc_valid", {32'd0, ifa.acc_valid}, 33'd0);
    chk("rst_acc_ovf", {32'd0, ifa.acc_ovf}, 33'd0);
    chk("rst_m_ready", {32'd0, ifa.m_ready}, 33'd1);
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Basic frame: 4 x 22500
    q_a.push_back(ex(1'b0, 32'd90000));
    for (int i = 0; i < 4; i++) send_a(16'd22500, 0);
    chk("basic_valid", {32'd0, ifa.acc_valid}, 33'd1);
    @(posedge clock); #1;
    chk("basic_after_acc", {9'd0, ifa.acc_out}, 33'd0);
    chk("basic_after_ready", {32'd0, ifa.m_ready}, 33'd1);
    chk("basic_after_valid", {32'd0, ifa.acc_valid}, 33'd0);

    // Gappy input, then back-pressure with m=7 waiting
    ifa.acc_ready = 1'b0;
    q_a.push_back(ex(1'b0, 32'd10));
    for (int i = 1; i <= 4; i++) send_a(16'(i), 1);
    ifa.m = 16'd7;
    ifa.m_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_acc", {9'd0, ifa.acc_out}, 33'd10);
      chk("hold_m_ready", {32'd0, ifa.m_ready}, 33'd0);
      chk("hold_valid", {32'd0, ifa.acc_valid}, 33'd1);
      @(posedge clock); #1;
    end
    ifa.acc_ready = 1'b1;
    @(posedge clock); #1;
    chk("handoff_no_accept", {9'd0, ifa.acc_out}, 33'd0);
    q_a.push_back(ex(1'b0, 32'd16));
    send_a(16'd7, 0);
    chk("next_frame_first", {9'd0, ifa.acc_out}, 33'd7);
    send_a(16'd2, 0);
    send_a(16'd3, 0);
    send_a(16'd4, 0);
    @(posedge clock); #1;

    // Clear mid-frame overrides a concurrent product
    send_a(16'd100, 0);
    send_a(16'd200, 0);
    chk("pre_clear_acc", {9'd0, ifa.acc_out}, 33'd300);
    ifa.m = 16'd300;
    ifa.m_valid = 1'b1;
    ifa.clear = 1'b1;
    @(posedge clock); #1;
    ifa.clear = 1'b0;
    ifa.m_valid = 1'b0;
    chk("clear_acc", {9'd0, ifa.acc_out}, 33'd0);
    chk("clear_m_ready", {32'd0, ifa.m_ready}, 33'd1);
    q_a.push_back(ex(1'b0, 32'd4));
    for (int i = 0; i < 4; i++) send_a(16'd1, 0);
    @(posedge clock); #1;

    // Overflow on the 16-bit instance
`ifdef DVSD_ACC_SATURATE_EN
    ovf_exp = ex(1'b1, 32'd65535);
`else
    ovf_exp = ex(1'b1, 32'd63492);
`endif
    q_b.push_back(ovf_exp);
    for (int i = 0; i < 4; i++) send_b(16'd65025);
    chk("ovf_flag_hold", {32'd0, ifb.acc_ovf}, 33'd1);
    @(posedge clock); #1;
    chk("ovf_cleared", {32'd0, ifb.acc_ovf}, 33'd0);
    chk("ovf_acc_cleared", {17'd0, ifb.acc_out}, 33'd0);
    q_b.push_back(ex(1'b0, 32'd4));
    for (int i = 0; i < 4; i++) send_b(16'd1);
    @(posedge clock); #1;

    // Async reset while a total is held
    ifa.acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(16'd5, 0);
    chk("pre_reset_valid", {32'd0, ifa.acc_valid}, 33'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", {32'd0, ifa.acc_valid}, 33'd0);
    chk("async_acc", {9'd0, ifa.acc_out}, 33'd0);
    chk("async_ovf", {32'd0, ifa.acc_ovf}, 33'd0);
    chk("async_m_ready", {32'd0, ifa.m_ready}, 33'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    ifa.acc_ready = 1'b1;
    q_a.push_back(ex(1'b0, 32'd100));
    send_a(16'd10, 0);
    send_a(16'd20, 0);
    send_a(16'd30, 0);
    send_a(16'd40, 0);
    repeat (3) begin
      @(posedge clock); #1;
    end

    chk("a_queue_drained", 33'(q_a.size()), 33'd0);
    chk("b_queue_drained", 33'(q_b.size()), 33'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvsd_8216acc.md
# dvsd_8216acc

Frame accumulator that sits directly downstream of the 8x8 multiplier and consumes its 16-bit product `m`. It sums a fixed number of products per frame and presents the frame total on a valid/ready output handshake. While a total is waiting to be taken, it applies back-pressure upstream. The block forms the accumulate half of the multiply-accumulate datapath.

## Interface
- `ACC_W`, 24: accumulator and output width in bits; legal range 16..32.
- `COUNT`, 4: products per frame; legal range 1..256.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m`  in  16  multiplier product, unsigned.
- `m_valid`  in  1  `m` holds a product to accumulate.
- `m_ready`  out  1  block accepts `m` this cycle.
- `clear`  in  1  synchronous frame abort, active-high.
- `acc_out`  out  ACC_W  accumulator value; it is the frame total when `acc_valid`=1.
- `acc_valid`  out  1  frame total available.
- `acc_ready`  in  1  downstream takes the total.
- `acc_ovf`  out  1  sticky flag: the current frame overflowed `ACC_W`.

One clock, `clock`. Reset `reset_n` is asynchronous and active-low.

## Operation
- The FSM has two states, ACCUM and HOLD. The product counter `cnt` is ceil(log2(COUNT)) bits wide, minimum 1 bit.
- Accept = `m_valid` & `m_ready`. `m_ready` = 1 in ACCUM and 0 in HOLD.
- ACCUM, on accept:
  - `acc` <= `acc` + zero-extend(`m`).
  - Carry out of bit ACC_W-1 sets `acc_ovf`.
  - If `cnt` == COUNT-1, go to HOLD and reset `cnt` to 0. Otherwise `cnt` increments.
- ACCUM without accept: all state holds. Gaps in `m_valid` are legal and have no effect.
- HOLD:
  - `acc_valid` = 1.
  - `acc_out` and `acc_ovf` are held stable until `acc_ready` = 1.
  - When `acc_ready` = 1, the total transfers. Next cycle: ACCUM, `acc` = 0, `acc_ovf` = 0, `acc_valid` = 0.
- No product is accepted in the handoff cycle, because `m_ready` = 0 in HOLD. An `m_valid` asserted then must be held by upstream.
- `clear` has the highest priority, in either state. Next cycle: ACCUM, `acc` = 0, `cnt` = 0, `acc_ovf` = 0, `acc_valid` = 0. Any pending total is dropped. `clear` overrides an accept or `acc_ready` in the same cycle.
- `acc_out` = `acc` at all times, registered with no combinational path from `m`.
- COUNT = 1: every accept goes straight to HOLD.

## Timing
- Reset values: `acc_out` = 0, `acc_valid` = 0, `acc_ovf` = 0, `m_ready` = 1 (ACCUM), `cnt` = 0.
- Reset assertion takes effect immediately, mid-frame or in HOLD. Release is synchronous to `clock`.
- Latency: `acc_valid` rises on the clock edge that accepts the COUNT-th product. The total is visible in the same cycle `acc_valid` is high.
- Minimum frame period is COUNT+1 cycles: COUNT accept cycles plus one handoff cycle.
- `m_ready` depends only on state, with no combinational path from `acc_ready`.

## Configuration
- Macro: `DVSD_ACC_SATURATE_EN`.
- Defined: an add that would overflow clamps `acc` to 2^ACC_W-1 and sets `acc_ovf`. Later products in the frame keep `acc` at 2^ACC_W-1.
- Undefined: `acc` wraps modulo 2^ACC_W and `acc_ovf` still sets. Total logic is an adder plus a sticky flag.
- The handshake and the FSM are identical in both builds.

## Test plan
- Basic frame (COUNT=4, ACC_W=24): four back-to-back products m=22500 (150×150) → `acc_valid`=1 after the 4th accept with `acc_out`=90000 (0x015F90) and `acc_ovf`=0. With `acc_ready`=1, `acc_out`=0 and `m_ready`=1 on the next cycle.
- Gappy input and back-pressure:
  - Products 1, 2, 3, 4 with `m_valid` low between each → `acc_out`=10.
  - Hold `acc_ready`=0 for 5 cycles → `acc_out`=10 stable, `m_ready`=0 throughout, and the `m`=7 presented during hold is not accepted.
  - Release → next frame begins with 7.
- Overflow (ACC_W=16, COUNT=4): four products m=65025 (255×255) → without the macro, `acc_out`=63492 and `acc_ovf`=1; with `DVSD_ACC_SATURATE_EN`, `acc_out`=65535 and `acc_ovf`=1. Next frame shows `acc_ovf`=0.
- Clear mid-frame: accept 100 and 200, pulse `clear` in the same cycle as a third `m_valid` with m=300 → 300 is not summed. A subsequent frame of 1, 1, 1, 1 yields `acc_out`=4.
- Async reset in HOLD: drop `reset_n` between clock edges while `acc_valid`=1 → `acc_valid`=0, `acc_out`=0, `acc_ovf`=0, `m_ready`=1 immediately. After release, a fresh 4-product frame sums correctly.
